burst_memory: RTL

Parametrised word memory with byte-enabled synchronous writes and a burst-read sequencer. A requester gives a start address and length; the block streams consecutive words over a valid/ready handshake with wrap-around addressing. It replaces the single-port asynchronous-read data memory in the datapath and feeds downstream consumers that may apply back-pressure.

---
 rtl/burst_memory.sv | 124 ++++++++++++
 1 files changed

// File: rtl/burst_memory.sv
// Word memory with byte-enabled synchronous writes and a burst-read sequencer
// streaming consecutive words (wrap-around) over a valid/ready handshake.
module burst_memory #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_adr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_start,
  input  logic [ADDR_W-1:0]     rd_adr,
  input  logic [LEN_W-1:0]      rd_len,
  output logic                  rd_busy,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned NB    = DATA_W / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  next_q, next_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  logic [IDX_W-1:0]  wr_idx_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic              load_c;

  assign wr_idx_c = wr_adr[IDX_W-1:0];

  // Upper address bits do not select a word.
  if (ADDR_W > IDX_W) begin : g_unused
    logic unused_adr_bits;
    assign unused_adr_bits = ^{wr_adr[ADDR_W-1:IDX_W], rd_adr[ADDR_W-1:IDX_W]};
  end

  // Storage is not reset; writes never wait on the read sequencer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx_c][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      next_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      next_q  <= next_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; array read samples pre-write contents on a collision.
  always_comb begin
    state_d  = state_q;
    next_d   = next_q;
    rem_d    = rem_q;
    data_d   = data_q;
    rd_idx_c = next_q;
    load_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_start && (rd_len != '0)) begin
          state_d  = STREAM;
          rd_idx_c = rd_adr[IDX_W-1:0];
          load_c   = 1'b1;
          next_d   = rd_adr[IDX_W-1:0] + IDX_W'(1);
          rem_d    = rd_len - LEN_W'(1);
        end
      end
      STREAM: begin
        if (rd_ready) begin
          if (rem_q != '0) begin
            load_c = 1'b1;
            next_d = next_q + IDX_W'(1);
            rem_d  = rem_q - LEN_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      data_d = mem_q[rd_idx_c];
    end
    last_d = (state_d == STREAM) && (rem_d == '0);
  end

  assign rd_busy  = (state_q == STREAM);
  assign rd_valid = (state_q == STREAM);
  assign rd_data  = data_q;
  assign rd_last  = last_q;

endmodule
